// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with mid-bit sampling and a one-entry valid/ready output
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Last count of a full bit period and of the half period before the start resample.
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic                   rx_m;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   perr;
  logic                   par_xor;
  logic                   par_bad;

  // Parity over the assembled word plus the bit currently on the line.
  assign par_xor = ^{shift, rx_s};
  assign par_bad = (PARITY == 1) ? ~par_xor : par_xor;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM, bit sampling and output register with valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              // Line went back high before mid start bit: treat as a glitch.
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
              end else begin
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PAR: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            perr    <= par_bad;
            bit_idx <= '0;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              // Bad stop bit: drop the word and wait out a break or stuck-low line.
              frame_err <= 1'b1;
              bit_idx   <= '0;
              state     <= S_BREAK;
            end else if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= S_IDLE;
              busy    <= 1'b0;
              if (!valid || ready) begin
                data       <= shift;
                parity_err <= (PARITY != 0) && perr;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed bench for uart_rx_os: 8N1 and 7E2 instances
module tb_uart_rx_os;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, valid_b;
  logic       perr_a, perr_b;
  logic       fe_a, fe_b;
  logic       ov_a, ov_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int fe_cnt, v_cnt, ov_cnt, bad_data, junk, flag_cnt, last_busy;
  bit busy_seen;

  typedef struct {
    bit         sel_b;
    logic [8:0] word;
    bit         par;
    logic [8:0] exp_data;
    bit         exp_perr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
    .parity_err(perr_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
  );

  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
    .parity_err(perr_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input bit sel_b, input logic val);
    if (sel_b) rx_b = val;
    else       rx_a = val;
  endtask

  task automatic hold_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Caller must be just after a rising edge; the stop level is left on the line.
  task automatic send_bits(input bit sel_b, input logic [8:0] word, input bit par, input logic stop_val);
    int nb;
    int ns;
    nb = sel_b ? 7 : 8;
    ns = sel_b ? 2 : 1;
    set_rx(sel_b, 1'b0);
    hold_bit();
    for (int i = 0; i < nb; i++) begin
      set_rx(sel_b, word[i]);
      hold_bit();
    end
    if (sel_b) begin
      set_rx(sel_b, par);
      hold_bit();
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(sel_b, stop_val);
      hold_bit();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int         lat;
    logic [8:0] got;
    logic       pe, fe, ov, vnext;
    lat = -1; got = '0; pe = 1'b0; fe = 1'b0; ov = 1'b0; vnext = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_bits(v.sel_b, v.word, v.par, 1'b1);
      begin
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk);
          @(negedge clk);
          if (v.sel_b ? valid_b : valid_a) begin
            lat = n;
            got = v.sel_b ? {2'b00, data_b} : {1'b0, data_a};
            pe  = v.sel_b ? perr_b : perr_a;
            fe  = v.sel_b ? fe_b : fe_a;
            ov  = v.sel_b ? ov_b : ov_a;
            @(negedge clk);
            vnext = v.sel_b ? valid_b : valid_a;
            break;
          end
        end
      end
    join
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_data"}, got, v.exp_data);
    check({tag, "_parity_err"}, pe, v.exp_perr);
    check({tag, "_frame_err"}, fe, 0);
    check({tag, "_overrun"}, ov, 0);
    check({tag, "_valid_cleared"}, vnext, 0);
  endtask

  initial begin
    vec_t v;
    // 8N1: latency 2 + 8 + 9*16 + 1 = 155; 7E2: 2 + 8 + 10*16 + 1 = 171.
    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 9'h0A5, 1'b0, 155};
    vecs[1] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 155};
    vecs[2] = '{1'b0, 9'h0FF, 1'b0, 9'h0FF, 1'b0, 155};
    vecs[3] = '{1'b0, 9'h080, 1'b0, 9'h080, 1'b0, 155};
    vecs[4] = '{1'b1, 9'h055, 1'b1, 9'h055, 1'b1, 171};
    vecs[5] = '{1'b1, 9'h055, 1'b0, 9'h055, 1'b0, 171};
    vecs[6] = '{1'b1, 9'h007, 1'b1, 9'h007, 1'b0, 171};
    vecs[7] = '{1'b1, 9'h007, 1'b0, 9'h007, 1'b1, 171};
    vecs[8] = '{1'b1, 9'h07F, 1'b1, 9'h07F, 1'b0, 171};

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid_a", valid_a, 0);
    check("reset_busy_a", busy_a, 0);
    check("reset_data_a", data_a, 0);
    check("reset_valid_b", valid_b, 0);
    check("reset_perr_b", perr_b, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (3) @(posedge clk);
    end

    // Six-cycle glitch: false start, no flags, busy drops quickly.
    busy_seen = 1'b0; last_busy = -1; flag_cnt = 0;
    @(posedge clk);
    #1 rx_a = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1 rx_a = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (busy_a) begin
            busy_seen = 1'b1;
            last_busy = i;
          end
          if (valid_a || fe_a || ov_a) flag_cnt++;
        end
      end
    join
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", (last_busy <= 12), 1);
    check("glitch_flags", flag_cnt, 0);

    // Low stop bit followed by a long break.
    fe_cnt = 0; v_cnt = 0;
    @(posedge clk);
    #1;
    fork
      begin
        send_bits(1'b0, 9'h05A, 1'b0, 1'b0);
        repeat (50 * CPB) @(posedge clk);
        #1 rx_a = 1'b1;
      end
      begin
        for (int i = 0; i < 60 * CPB; i++) begin
          @(negedge clk);
          if (fe_a) fe_cnt++;
          if (valid_a) v_cnt++;
        end
      end
    join
    check("break_frame_err_count", fe_cnt, 1);
    check("break_no_valid", v_cnt, 0);
    check("break_busy_held", busy_a, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("break_busy_released", busy_a, 0);
    repeat (10) @(posedge clk);
    v = '{1'b0, 9'h03C, 1'b0, 9'h03C, 1'b0, 155};
    run_vec(v, "after_break");

    // Back-to-back frames with the consumer stalled.
    ready_a = 1'b0; ov_cnt = 0; bad_data = 0; fe_cnt = 0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    fork
      begin
        send_bits(1'b0, 9'h011, 1'b0, 1'b1);
        send_bits(1'b0, 9'h022, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 330; i++) begin
          @(negedge clk);
          if (ov_a) ov_cnt++;
          if (fe_a) fe_cnt++;
          if (valid_a && data_a !== 8'h11) bad_data++;
        end
      end
    join
    check("overrun_count", ov_cnt, 1);
    check("overrun_data_stable", bad_data, 0);
    check("overrun_no_frame_err", fe_cnt, 0);
    check("overrun_valid_held", valid_a, 1);
    check("overrun_data", data_a, 8'h11);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(negedge clk);
    check("ready_raise_valid_still", valid_a, 1);
    @(negedge clk);
    check("ready_raise_valid_cleared", valid_a, 0);

    // Reset during bit 4 of 0xFF.
    junk = 0;
    repeat (5) @(posedge clk);
    #1;
    fork
      send_bits(1'b0, 9'h0FF, 1'b0, 1'b1);
      begin
        repeat (87) @(posedge clk);
        @(negedge clk);
        check("midframe_busy", busy_a, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_parity_err", perr_a, 0);
        check("rst_frame_err", fe_a, 0);
        check("rst_overrun", ov_a, 0);
        check("rst_busy", busy_a, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (valid_a || fe_a || busy_a) junk++;
        end
      end
    join
    check("rst_abort_quiet", junk, 0);
    repeat (5) @(posedge clk);
    v = '{1'b0, 9'h081, 1'b0, 9'h081, 1'b0, 155};
    run_vec(v, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver: the next generation of the team's fixed 8N1 receiver. Runs on the system clock rather than a baud-rate clock. Samples each bit at its midpoint and supports configurable data width, parity and stop bits. Detects false starts, framing, parity and overrun errors, and presents each received word on a single-entry valid/ready output register. It sits between the board RX pin and the matrix-load path that consumes received operands.

## Interface
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range ≥ 4.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx  in  1  asynchronous serial input; idles high
- data  out  DATA_BITS  received word, LSB = first bit on the line
- valid  out  1  data holds an unconsumed word
- ready  in  1  consumer accepts data when valid && ready
- parity_err  out  1  parity mismatch for the word in data; qualified by valid
- frame_err  out  1  one-cycle pulse: a stop bit was sampled low
- overrun  out  1  one-cycle pulse: a completed word was dropped because valid was still set
- busy  out  1  high in every state except IDLE

## Operation
- rx passes through a 2-flop synchroniser (rx_s) before any use; the synchroniser resets to 1.
- All sampling uses a baud counter of width clog2(CLKS_PER_BIT) and a bit counter of width clog2(DATA_BITS+1).
- FSM states and transitions:
  - IDLE: when rx_s == 0, go to START and clear the counter.
  - START: wait (CLKS_PER_BIT/2)−1 cycles, then resample rx_s.
    - Resample is 1: false start; return to IDLE with no flags.
    - Resample is 0: go to DATA with the counter cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit_idx].
    - After DATA_BITS samples, go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit.
    - Odd parity: mismatch when XOR(data bits, parity bit) == 0.
    - Even parity: mismatch when that XOR == 1.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit; repeat STOP_BITS times.
    - Any stop sample is 0: pulse frame_err, discard the word, go to BREAK.
    - All stop samples are 1: deliver the word, go to IDLE.
  - BREAK: wait until rx_s == 1, then go to IDLE. Handles line breaks and stuck-low lines.
- Delivery rules:
  - If valid == 0, or valid && ready in the same cycle: load data and parity_err, set valid.
  - If valid && !ready: keep the old data, drop the new word, pulse overrun.
- Handshake rules:
  - valid clears on the cycle after valid && ready, unless a new word is delivered in that same cycle.
  - data and parity_err stay stable while valid && !ready.
- Reset values: data = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0; FSM is IDLE; all counters are 0.
- rst asserted mid-frame aborts the frame. The next frame is received only after a fresh falling edge following rst release.
- With PARITY = 0, parity_err is tied 0.

## Timing
- Synchroniser latency: 2 clk cycles.
- Start detection to START resample: CLKS_PER_BIT/2 cycles, so sampling lands at mid-bit. Odd CLKS_PER_BIT rounds down.
- Each later sample is exactly CLKS_PER_BIT cycles after the previous one.
- valid rises 1 cycle after the final stop-bit sample.
  - Falling edge on rx to valid = 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if PARITY ≠ 0, else 0.
- frame_err and overrun assert in the same cycle valid would have risen, for exactly 1 cycle.
- After a good frame the FSM is in IDLE during the second half of the last stop bit, so back-to-back frames are received with no gap.
- Accepted rx baud error: ±(CLKS_PER_BIT/2 − 1)/(frame bits · CLKS_PER_BIT) of a bit period, measured over the whole frame.

## Test plan
- Default parameters (8N1, CLKS_PER_BIT = 16), ready = 1, frame 0xA5 -> valid for 1 cycle with data = 0xA5, 155 cycles after the falling edge; no flags.
- PARITY = 2, DATA_BITS = 7, STOP_BITS = 2:
  - Send 0x55 with parity bit 1 -> data = 0x55, parity_err = 1.
  - Repeat with parity bit 0 -> parity_err = 0.
- Glitch on rx: low for 6 cycles -> no valid, no flags; busy returns to 0 within 8 cycles of the glitch.
- Stop bit forced 0, then rx held low for 50 bit times -> one frame_err pulse only; no valid while rx stays low. A frame 0x3C sent after release -> data = 0x3C.
- ready = 0, send 0x11 then 0x22 back-to-back -> data stays 0x11 and overrun pulses once at the end of 0x22. Raising ready then clears valid the next cycle.
- Assert rst mid-frame during bit 4 of 0xFF -> all outputs 0. A following frame 0x81 -> data = 0x81, valid = 1, no error flags.
